frame_swap_ctrl: RTL and testbench

//  Sequences the double-buffered frame buffer: routes painter pixel writes to the back RGB plane or to the special strip.
//  On swap request, waits for VGA vertical sync, flips front/back, then optionally clears the new back plane.

---
 rtl/frame_swap_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_frame_swap_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_swap_ctrl.sv
// Double-buffered frame sequencer: routes Painter writes to the back RGB plane or the
// special strip, flips front/back on the vsync after a swap request, then clears the new back plane.
module frame_swap_ctrl #(
   parameter int         PLANE_SIZE   = 19200,
   parameter int         SPECIAL_SIZE = 1600,
   parameter int         ADDR_W       = 16,
   parameter bit         CLEAR_EN     = 1'b1,
   parameter logic [2:0] CLEAR_COLOR  = 3'b000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              swap_req,
   input  logic              p_we,
   input  logic [15:0]       p_addr,
   input  logic [2:0]        p_color,
   output logic              p_ready,
   output logic              rgb_we,
   output logic [ADDR_W-1:0] rgb_addr,
   output logic [2:0]        rgb_data,
   output logic              sp_we,
   output logic [10:0]       sp_addr,
   output logic [2:0]        sp_data,
   output logic              front_sel,
   output logic              swap_done,
   output logic              addr_err
);

   localparam int CNT_W = $clog2(PLANE_SIZE);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT_VS = 2'd1;
   localparam logic [1:0] S_SWAP    = 2'd2;
   localparam logic [1:0] S_CLEAR   = 2'd3;

   localparam logic [15:0]       SP_BASE   = 16'(PLANE_SIZE);
   localparam logic [15:0]       SP_END    = 16'(PLANE_SIZE + SPECIAL_SIZE);
   localparam logic [ADDR_W-1:0] PLANE_OFS = ADDR_W'(PLANE_SIZE);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PLANE_SIZE - 1);

   // Both planes must fit the physical RGB address space; the special strip must fit sp_addr.
   generate
      if (2 * PLANE_SIZE >= (1 << ADDR_W)) begin : g_plane_size_chk
         $error("frame_swap_ctrl: 2*PLANE_SIZE does not fit in ADDR_W bits");
      end
      if (SPECIAL_SIZE > 2048) begin : g_special_size_chk
         $error("frame_swap_ctrl: SPECIAL_SIZE does not fit the 11-bit special address");
      end
      if (PLANE_SIZE + SPECIAL_SIZE > 65536) begin : g_logical_size_chk
         $error("frame_swap_ctrl: logical address range exceeds 16-bit p_addr");
      end
   endgenerate

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CNT_W-1:0]  clr_cnt;
   logic              vs_meta;
   logic              vs_cur;
   logic              vs_prev;
   logic              vs_fall;
   logic              in_rgb;
   logic              in_sp;
   logic              clr_last;
   logic [ADDR_W-1:0] back_base;

   // ---------------------------------------------------------------------
   // vsync synchroniser and falling-edge detector (vgaClk -> clk)
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_meta <= 1'b1;
         vs_cur  <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         vs_meta <= vsync;
         vs_cur  <= vs_meta;
         vs_prev <= vs_cur;
      end
   end

   // Edge is only consumed in WAIT_VS; a fall seen in any other state is simply dropped.
   assign vs_fall = vs_prev & ~vs_cur;

   // ---------------------------------------------------------------------
   // Address decode and plane selection
   // ---------------------------------------------------------------------
   assign p_ready   = (state == S_IDLE);
   assign in_rgb    = (p_addr < SP_BASE);
   assign in_sp     = !in_rgb && (p_addr < SP_END);
   assign back_base = front_sel ? '0 : PLANE_OFS;
   assign clr_last  = (clr_cnt == CNT_LAST);

   // ---------------------------------------------------------------------
   // Sequencer next state
   // ---------------------------------------------------------------------
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (swap_req) state_nxt = S_WAIT_VS;
         end
         S_WAIT_VS: begin
            if (vs_fall) state_nxt = S_SWAP;
         end
         S_SWAP: begin
            state_nxt = CLEAR_EN ? S_CLEAR : S_IDLE;
         end
         S_CLEAR: begin
            if (clr_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         front_sel <= 1'b0;
         clr_cnt   <= '0;
         swap_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         swap_done <= 1'b0;
         case (state)
            S_SWAP: begin
               front_sel <= ~front_sel;
               clr_cnt   <= '0;
               if (!CLEAR_EN) swap_done <= 1'b1;
            end
            S_CLEAR: begin
               clr_cnt <= clr_cnt + CNT_W'(1);
               // Final clear write and swap_done leave the registers on the same edge.
               if (clr_last) swap_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registered write port to the RGB and special RAMs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_we   <= 1'b0;
         rgb_addr <= '0;
         rgb_data <= '0;
         sp_we    <= 1'b0;
         sp_addr  <= '0;
         sp_data  <= '0;
         addr_err <= 1'b0;
      end else begin
         rgb_we <= 1'b0;
         sp_we  <= 1'b0;
         case (state)
            S_IDLE: begin
               // front_sel cannot change in IDLE, so a write alongside swap_req lands in the old back plane.
               if (p_we) begin
                  if (in_rgb) begin
                     rgb_we   <= 1'b1;
                     rgb_addr <= ADDR_W'(p_addr) + back_base;
                     rgb_data <= p_color;
                  end else if (in_sp) begin
                     sp_we   <= 1'b1;
                     sp_addr <= 11'(p_addr - SP_BASE);
                     sp_data <= p_color;
                  end else begin
                     addr_err <= 1'b1;
                  end
               end
            end
            S_CLEAR: begin
               // front_sel has already toggled here, so back_base points at the new back plane.
               rgb_we   <= 1'b1;
               rgb_addr <= back_base + ADDR_W'(clr_cnt);
               rgb_data <= CLEAR_COLOR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Directed self-checking bench for frame_swap_ctrl: one instance with the clear pass
// enabled and a second built with CLEAR_EN=0.
module tb_frame_swap_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync, swap_req, p_we;
   logic [15:0] p_addr;
   logic [2:0]  p_color;
   logic        p_ready, rgb_we, sp_we, front_sel, swap_done, addr_err;
   logic [15:0] rgb_addr;
   logic [2:0]  rgb_data, sp_data;
   logic [10:0] sp_addr;

   logic        vsync_b, swap_req_b, p_we_b;
   logic [15:0] p_addr_b;
   logic [2:0]  p_color_b;
   logic        p_ready_b, rgb_we_b, sp_we_b, front_sel_b, swap_done_b, addr_err_b;
   logic [15:0] rgb_addr_b;
   logic [2:0]  rgb_data_b, sp_data_b;
   logic [10:0] sp_addr_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   frame_swap_ctrl #(.CLEAR_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .vsync(vsync), .swap_req(swap_req),
      .p_we(p_we), .p_addr(p_addr), .p_color(p_color), .p_ready(p_ready),
      .rgb_we(rgb_we), .rgb_addr(rgb_addr), .rgb_data(rgb_data),
      .sp_we(sp_we), .sp_addr(sp_addr), .sp_data(sp_data),
      .front_sel(front_sel), .swap_done(swap_done), .addr_err(addr_err)
   );

   frame_swap_ctrl #(.CLEAR_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .vsync(vsync_b), .swap_req(swap_req_b),
      .p_we(p_we_b), .p_addr(p_addr_b), .p_color(p_color_b), .p_ready(p_ready_b),
      .rgb_we(rgb_we_b), .rgb_addr(rgb_addr_b), .rgb_data(rgb_data_b),
      .sp_we(sp_we_b), .sp_addr(sp_addr_b), .sp_data(sp_data_b),
      .front_sel(front_sel_b), .swap_done(swap_done_b), .addr_err(addr_err_b)
   );

   // Inputs change and outputs are sampled 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; vsync = 1'b1; swap_req = 1'b0; p_we = 1'b0; p_addr = '0; p_color = '0;
      vsync_b = 1'b1; swap_req_b = 1'b0; p_we_b = 1'b0; p_addr_b = '0; p_color_b = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      checks++; if (p_ready !== 1'b1) begin failures++; $display("FAIL reset_p_ready: got %b want 1", p_ready); end
      checks++; if (front_sel !== 1'b0) begin failures++; $display("FAIL reset_front_sel: got %b want 0", front_sel); end
      checks++;
      if ({rgb_we, sp_we, swap_done, addr_err} !== 4'b0000) begin
         failures++; $display("FAIL reset_flags: got %b want 0000", {rgb_we, sp_we, swap_done, addr_err});
      end
      checks++;
      if ({rgb_addr, sp_addr, rgb_data, sp_data} !== 33'd0) begin
         failures++; $display("FAIL reset_addr_data: got rgb_addr=%0d sp_addr=%0d want 0", rgb_addr, sp_addr);
      end
   endtask

   task automatic test_rgb_write();
      p_we = 1'b1; p_addr = 16'd5; p_color = 3'b101;
      tick();
      p_we = 1'b0;
      checks++; if (rgb_we !== 1'b1) begin failures++; $display("FAIL rgb_we: got %b want 1", rgb_we); end
      checks++; if (rgb_addr !== 16'd19205) begin failures++; $display("FAIL rgb_addr: got %0d want 19205", rgb_addr); end
      checks++; if (rgb_data !== 3'b101) begin failures++; $display("FAIL rgb_data: got %b want 101", rgb_data); end
      checks++; if (sp_we !== 1'b0) begin failures++; $display("FAIL rgb_sp_we: got %b want 0", sp_we); end
      tick();
      checks++; if (rgb_we !== 1'b0) begin failures++; $display("FAIL rgb_we_pulse: got %b want 0", rgb_we); end
      // Back-to-back writes, including the last RGB pixel.
      p_we = 1'b1; p_addr = 16'd0; p_color = 3'b111;
      tick();
      checks++;
      if ({rgb_we, rgb_addr, rgb_data} !== {1'b1, 16'd19200, 3'b111}) begin
         failures++; $display("FAIL b2b_first: got we=%b addr=%0d data=%b want we=1 addr=19200 data=111", rgb_we, rgb_addr, rgb_data);
      end
      p_addr = 16'd19199; p_color = 3'b010;
      tick();
      p_we = 1'b0;
      checks++;
      if ({rgb_we, rgb_addr, rgb_data} !== {1'b1, 16'd38399, 3'b010}) begin
         failures++; $display("FAIL b2b_last_rgb: got we=%b addr=%0d data=%b want we=1 addr=38399 data=010", rgb_we, rgb_addr, rgb_data);
      end
      tick();
   endtask

   task automatic test_special();
      p_we = 1'b1; p_addr = 16'd19210; p_color = 3'b011;
      tick();
      checks++;
      if ({sp_we, sp_addr, sp_data, rgb_we} !== {1'b1, 11'd10, 3'b011, 1'b0}) begin
         failures++; $display("FAIL sp_write: got sp_we=%b sp_addr=%0d sp_data=%b rgb_we=%b want 1 10 011 0", sp_we, sp_addr, sp_data, rgb_we);
      end
      p_addr = 16'd20799; p_color = 3'b100;
      tick();
      checks++;
      if ({sp_we, sp_addr, sp_data} !== {1'b1, 11'd1599, 3'b100}) begin
         failures++; $display("FAIL sp_last: got sp_we=%b sp_addr=%0d sp_data=%b want 1 1599 100", sp_we, sp_addr, sp_data);
      end
      checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL sp_last_err: got %b want 0", addr_err); end
      p_addr = 16'd20800;
      tick();
      p_we = 1'b0;
      checks++;
      if ({rgb_we, sp_we, addr_err} !== 3'b001) begin
         failures++; $display("FAIL out_of_range: got rgb_we=%b sp_we=%b addr_err=%b want 0 0 1", rgb_we, sp_we, addr_err);
      end
      repeat (5) tick();
      checks++; if (addr_err !== 1'b1) begin failures++; $display("FAIL addr_err_sticky: got %b want 1", addr_err); end
   endtask

   task automatic test_swap_clear();
      bit seen, done, gap, early_ready, sp_seen, bad_addr;
      int n;
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      early_ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (p_ready !== 1'b0 || front_sel !== 1'b0) early_ready = 1'b1;
      end
      checks++; if (early_ready) begin failures++; $display("FAIL wait_vs_hold: p_ready/front_sel changed, want 0/0 while vsync high"); end
      vsync = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         tick();
         if (front_sel === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL swap_latency: front_sel=%b want 1 within 4 cycles", front_sel); end
      n = 0; done = 0; gap = 0; early_ready = 0; sp_seen = 0; bad_addr = 0;
      for (int i = 0; i < 19210 && !done; i++) begin
         tick();
         if (rgb_we === 1'b1) begin
            if (rgb_addr !== 16'(n) || rgb_data !== 3'b000) bad_addr = 1'b1;
            n++;
         end else if (n > 0) begin
            gap = 1'b1;
         end
         if (sp_we === 1'b1) sp_seen = 1'b1;
         if (swap_done === 1'b1) done = 1'b1;
         else if (p_ready === 1'b1) early_ready = 1'b1;
      end
      checks++; if (!done) begin failures++; $display("FAIL clear_done_timeout: swap_done=0 want 1"); end
      checks++; if (n !== 19200) begin failures++; $display("FAIL clear_count: got %0d writes want 19200", n); end
      checks++; if (bad_addr || gap) begin failures++; $display("FAIL clear_sequence: bad_addr=%b gap=%b want 0 0", bad_addr, gap); end
      checks++; if (sp_seen || early_ready) begin failures++; $display("FAIL clear_side: sp_we_seen=%b early_ready=%b want 0 0", sp_seen, early_ready); end
      checks++;
      if ({rgb_we, rgb_addr, p_ready} !== {1'b1, 16'd19199, 1'b1}) begin
         failures++; $display("FAIL clear_last: got we=%b addr=%0d p_ready=%b want 1 19199 1", rgb_we, rgb_addr, p_ready);
      end
      tick();
      checks++;
      if ({swap_done, rgb_we, p_ready, front_sel} !== 4'b0011) begin
         failures++; $display("FAIL after_clear: got done=%b we=%b ready=%b front=%b want 0 0 1 1", swap_done, rgb_we, p_ready, front_sel);
      end
   endtask

   task automatic test_post_swap_write();
      p_we = 1'b1; p_addr = 16'd5; p_color = 3'b110;
      tick();
      p_we = 1'b0;
      checks++;
      if ({rgb_we, rgb_addr, rgb_data} !== {1'b1, 16'd5, 3'b110}) begin
         failures++; $display("FAIL post_swap_write: got we=%b addr=%0d data=%b want 1 5 110", rgb_we, rgb_addr, rgb_data);
      end
      tick();
   endtask

   task automatic test_no_clear();
      bit seen, wrote;
      swap_req_b = 1'b1;
      tick();
      swap_req_b = 1'b0;
      repeat (5) tick();
      checks++; if (p_ready_b !== 1'b0) begin failures++; $display("FAIL noclr_wait: p_ready=%b want 0", p_ready_b); end
      vsync_b = 1'b0;
      seen = 0; wrote = 0;
      for (int i = 0; i < 6 && !seen; i++) begin
         tick();
         if (rgb_we_b === 1'b1) wrote = 1'b1;
         if (front_sel_b === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL noclr_swap_timeout: front_sel=%b want 1", front_sel_b); end
      checks++;
      if ({swap_done_b, p_ready_b, rgb_we_b, wrote} !== 4'b1100) begin
         failures++; $display("FAIL noclr_done: got done=%b ready=%b we=%b wrote=%b want 1 1 0 0", swap_done_b, p_ready_b, rgb_we_b, wrote);
      end
      tick();
      checks++;
      if ({swap_done_b, rgb_we_b} !== 2'b00) begin
         failures++; $display("FAIL noclr_pulse: got done=%b we=%b want 0 0", swap_done_b, rgb_we_b);
      end
      p_we_b = 1'b1; p_addr_b = 16'd5; p_color_b = 3'b001;
      tick();
      p_we_b = 1'b0;
      checks++;
      if ({rgb_we_b, rgb_addr_b} !== {1'b1, 16'd5}) begin
         failures++; $display("FAIL noclr_write: got we=%b addr=%0d want 1 5", rgb_we_b, rgb_addr_b);
      end
   endtask

   task automatic test_swap_with_write();
      reset = 1'b1; vsync = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      checks++; if ({front_sel, addr_err} !== 2'b00) begin failures++; $display("FAIL rereset: front=%b err=%b want 0 0", front_sel, addr_err); end
      swap_req = 1'b1; p_we = 1'b1; p_addr = 16'd7; p_color = 3'b110;
      tick();
      swap_req = 1'b0; p_addr = 16'd3;
      checks++;
      if ({rgb_we, rgb_addr, rgb_data, p_ready} !== {1'b1, 16'd19207, 3'b110, 1'b0}) begin
         failures++; $display("FAIL swap_and_write: got we=%b addr=%0d data=%b ready=%b want 1 19207 110 0", rgb_we, rgb_addr, rgb_data, p_ready);
      end
      repeat (2) tick();
      p_we = 1'b0;
      checks++;
      if ({rgb_we, sp_we} !== 2'b00) begin
         failures++; $display("FAIL write_in_wait: got rgb_we=%b sp_we=%b want 0 0", rgb_we, sp_we);
      end
   endtask

   task automatic test_reset_mid_clear();
      bit hit;
      vsync = 1'b0;
      hit = 0;
      for (int i = 0; i < 600 && !hit; i++) begin
         tick();
         if (rgb_we === 1'b1 && rgb_addr === 16'd499) hit = 1'b1;
      end
      checks++; if (!hit) begin failures++; $display("FAIL mid_clear_timeout: clear write 499 not seen"); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({rgb_we, front_sel, p_ready, swap_done} !== 4'b0010) begin
         failures++; $display("FAIL mid_clear_reset: got we=%b front=%b ready=%b done=%b want 0 0 1 0", rgb_we, front_sel, p_ready, swap_done);
      end
      repeat (3) tick();
      checks++; if ({rgb_we, front_sel} !== 2'b00) begin failures++; $display("FAIL mid_clear_resume: we=%b front=%b want 0 0", rgb_we, front_sel); end
   endtask

   task automatic test_idle_vsync();
      bit bad, seen, done;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         vsync = 1'b1; repeat (5) tick();
         vsync = 1'b0; repeat (5) tick();
         if (front_sel !== 1'b0 || p_ready !== 1'b1) bad = 1'b1;
      end
      checks++; if (bad) begin failures++; $display("FAIL idle_vsync: front_sel toggled or p_ready dropped in IDLE"); end
      // vsync already low when the request arrives: no edge, no swap.
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      repeat (20) tick();
      checks++; if ({front_sel, p_ready} !== 2'b00) begin failures++; $display("FAIL stale_low: front=%b ready=%b want 0 0", front_sel, p_ready); end
      vsync = 1'b1; repeat (5) tick();
      vsync = 1'b0;
      seen = 0;
      for (int i = 0; i < 4 && !seen; i++) begin
         tick();
         if (front_sel === 1'b1) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL fresh_edge: front_sel=%b want 1 within 4 cycles", front_sel); end
      done = 0;
      for (int i = 0; i < 19300 && !done; i++) begin
         tick();
         if (swap_done === 1'b1) done = 1'b1;
      end
      checks++; if (!done || p_ready !== 1'b1) begin failures++; $display("FAIL second_clear: done=%b ready=%b want 1 1", done, p_ready); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rgb_write();
      test_special();
      test_swap_clear();
      test_post_swap_write();
      test_no_clear();
      test_swap_with_write();
      test_reset_mid_clear();
      test_idle_vsync();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
